bp_me_dma_channel_arbiter: RTL and testbench
============================================

// Module: bp_me_dma_channel_arbiter
// PURPOSE
// - Merges N DMA requesters (L2 cache banks plus uncached bypass) onto one DMA port to the memory controller.
// - Arbitrates request packets and tracks outstanding reads and writes in order queues.
// - Steers each beat of read-return and write data to or from the requester that owns it.
// - Multiple requests may be in flight, and requesters need not be mutually exclusive.
// - Sits between the bsg_cache banks or bypass engine and the DRAM/DMA link.
// PARAMETERS
// - num_chan_p       3  number of requesting channels (>=1)
// - pkt_width_p      33 DMA packet width; bit [pkt_width_p-1] is write_not_read
// - data_width_p     64 DMA data beat width (l2_fill_width_p)
// - block_beats_p    8  data beats per DMA packet (>=1)
// - max_rd_p         4  read order-queue depth (max outstanding reads)
// - max_wr_p         2  write order-queue depth (max writes awaiting data)
// - fixed_prio_p     0  0 = round-robin; 1 = fixed priority, channel 0 highest
// PORTS
// - clk_i                   in   1                       clock
// - reset_n_i               in   1                       async active-low reset
// - chan_pkt_i              in   num_chan_p*pkt_width_p  per-channel DMA packet
// - chan_pkt_v_i            in   num_chan_p              packet valid
// - chan_pkt_ready_and_o    out  num_chan_p              packet accepted
// - chan_wdata_i            in   num_chan_p*data_width_p write data from each channel
// - chan_wdata_v_i          in   num_chan_p              write data valid
// - chan_wdata_ready_and_o  out  num_chan_p              write data accepted
// - chan_rdata_o            out  num_chan_p*data_width_p read data to each channel (broadcast)
// - chan_rdata_v_o          out  num_chan_p              read data valid (one-hot or 0)
// - chan_rdata_ready_and_i  in   num_chan_p              channel accepts read data
// - dma_pkt_o               out  pkt_width_p             merged packet
// - dma_pkt_v_o             out  1                       merged packet valid
// - dma_pkt_ready_and_i     in   1                       downstream accepts packet
// - dma_data_o              out  data_width_p            merged write data
// - dma_data_v_o            out  1                       write data valid
// - dma_data_ready_and_i    in   1                       downstream accepts write data
// - dma_data_i              in   data_width_p            read return data
// - dma_data_v_i            in   1                       read return valid
// - dma_data_ready_and_o    out  1                       read return accepted
// BEHAVIOUR
// - All handshakes are ready-and-valid; a transfer occurs when v & ready_and are high at the rising clk_i edge.
// - Reset (reset_n_i low, asynchronous):
//   - queues empty, beat counters 0, round-robin pointer 0;
//   - every *_v_o and *_ready_and_o is 0 while reset is asserted and in the first cycle after it.
//   - A reset mid-burst discards all in-flight state without any draining.
// - Eligibility:
//   - Channel i is eligible if chan_pkt_v_i[i] is high and its target queue is not full.
//   - The target queue is the write queue if the packet MSB is 1, else the read queue.
//   - A full queue blocks its push even when a pop happens in the same cycle (conservative rule).
// - Grant:
//   - Combinational and one-hot among eligible channels.
//   - Round-robin: search starts at the pointer; on a packet handshake the pointer becomes winner+1 mod num_chan_p.
//   - fixed_prio_p=1: the lowest-index eligible channel wins.
// - Packet outputs:
//   - dma_pkt_v_o = any channel eligible; dma_pkt_o = winner's packet.
//   - chan_pkt_ready_and_o[w] = dma_pkt_ready_and_i for the winner w; 0 for all others.
//   - The grant must not change while dma_pkt_v_o is high and no handshake has occurred (sticky grant); the pointer is held.
// - Queue push: on a packet handshake, push winner ID (clog2 width, min 1) into the read or write queue.
//   - Zero-cycle latency from packet accept to queue visibility.
// - Write data path:
//   - While the write queue is non-empty, h = head ID.
//   - dma_data_v_o = chan_wdata_v_i[h]; dma_data_o = chan_wdata_i[h].
//   - chan_wdata_ready_and_o[h] = dma_data_ready_and_i; all other channels get 0.
//   - Each beat handshake increments wcnt. When wcnt == block_beats_p-1 at a handshake, wcnt returns to 0 and the queue pops.
//   - Write data may arrive before its packet handshake; it is held off, with ready 0, until its ID is at the head.
// - Read data path:
//   - While the read queue is non-empty, h = head ID.
//   - chan_rdata_v_o[h] = dma_data_v_i; chan_rdata_o = dma_data_i for all channels.
//   - dma_data_ready_and_o = chan_rdata_ready_and_i[h].
//   - rcnt works the same as wcnt and pops the read queue on the final beat.
//   - Empty read queue: dma_data_ready_and_o = 0 and all chan_rdata_v_o = 0. An unexpected beat stalls; an assertion fires in simulation.
// - Concurrency:
//   - A packet grant, a write beat and a read beat may all occur in the same cycle.
//   - A push and pop on the same queue in one cycle leave the count unchanged.
// - No combinational path from any ready_and_i to any *_v_o.
// TESTING
// - Single read:
//   - Stimulus: ch1 read pkt, then 8 return beats 0..7.
//   - Response: 1-cycle pkt handshake; chan_rdata_v_o=3'b010 on all 8 beats; read queue empty afterwards.
// - Round-robin:
//   - Stimulus: ch0/1/2 issue reads continuously, dma_pkt_ready_and_i=1.
//   - Response: grant order 0,1,2,0 holds until the read queue is full (4), then dma_pkt_v_o=0.
// - Interleave:
//   - Stimulus: ch0 write pkt + 8 beats with ch2 read returns in the same cycles.
//   - Response: both paths complete in 8 cycles with no cross-steering.
// - Backpressure:
//   - Stimulus: dma_pkt_ready_and_i toggles 0/1 while ch0 and ch1 are valid.
//   - Response: dma_pkt_o stays stable while stalled, and no grant switch occurs before the handshake.
// - Fixed priority:
//   - Stimulus: fixed_prio_p=1 with ch0 and ch2 permanently valid.
//   - Response: ch0 always wins; ch2 is starved only while ch0 is eligible.
// - Reset mid-burst:
//   - Stimulus: drop reset_n_i after beat 3 of a read.
//   - Response: outputs go to 0 immediately, queues are empty after reset, and a new read is steered correctly.

Source files
------------

// File: rtl/bp_me_dma_channel_arbiter.sv
// Merges several DMA requesters onto one DMA port. Per-direction order queues of
// requester IDs steer write-data and read-return beats to and from their owners.
module bp_me_dma_channel_arbiter #(
  parameter int num_chan_p    = 3,
  parameter int pkt_width_p   = 33,
  parameter int data_width_p  = 64,
  parameter int block_beats_p = 8,
  parameter int max_rd_p      = 4,
  parameter int max_wr_p      = 2,
  parameter int fixed_prio_p  = 0
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_chan_p*pkt_width_p-1:0]   chan_pkt_i,
  input  logic [num_chan_p-1:0]               chan_pkt_v_i,
  output logic [num_chan_p-1:0]               chan_pkt_ready_and_o,
  input  logic [num_chan_p*data_width_p-1:0]  chan_wdata_i,
  input  logic [num_chan_p-1:0]               chan_wdata_v_i,
  output logic [num_chan_p-1:0]               chan_wdata_ready_and_o,
  output logic [num_chan_p*data_width_p-1:0]  chan_rdata_o,
  output logic [num_chan_p-1:0]               chan_rdata_v_o,
  input  logic [num_chan_p-1:0]               chan_rdata_ready_and_i,
  output logic [pkt_width_p-1:0]              dma_pkt_o,
  output logic                                dma_pkt_v_o,
  input  logic                                dma_pkt_ready_and_i,
  output logic [data_width_p-1:0]             dma_data_o,
  output logic                                dma_data_v_o,
  input  logic                                dma_data_ready_and_i,
  input  logic [data_width_p-1:0]             dma_data_i,
  input  logic                                dma_data_v_i,
  output logic                                dma_data_ready_and_o
);

  localparam int IdW   = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam int RPtrW = (max_rd_p > 1) ? $clog2(max_rd_p) : 1;
  localparam int WPtrW = (max_wr_p > 1) ? $clog2(max_wr_p) : 1;
  localparam int RCntW = $clog2(max_rd_p + 1);
  localparam int WCntW = $clog2(max_wr_p + 1);
  localparam int BeatW = (block_beats_p > 1) ? $clog2(block_beats_p) : 1;

  // live_q[1] rises on the second clock edge after reset, keeping all
  // valids and readies low through the first cycle out of reset.
  logic [1:0]       live_q;
  logic             active;

  logic [IdW-1:0]   rq_mem_q [max_rd_p];
  logic [RPtrW-1:0] rq_rptr_q, rq_rptr_d, rq_wptr_q, rq_wptr_d;
  logic [RCntW-1:0] rq_cnt_q, rq_cnt_d;
  logic [IdW-1:0]   wq_mem_q [max_wr_p];
  logic [WPtrW-1:0] wq_rptr_q, wq_rptr_d, wq_wptr_q, wq_wptr_d;
  logic [WCntW-1:0] wq_cnt_q, wq_cnt_d;
  logic [BeatW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [IdW-1:0]   rr_q, rr_d, lock_id_q, lock_id_d;
  logic             lock_v_q, lock_v_d;

  logic [num_chan_p-1:0]  elig;
  logic                   any_elig;
  logic [IdW-1:0]         grant;
  logic [pkt_width_p-1:0] win_pkt;
  logic                   pkt_hs, rq_push, wq_push;
  logic                   rq_full, wq_full, rq_act, wq_act;
  logic [IdW-1:0]         rq_head, wq_head;
  logic                   w_hs, w_last, r_hs, r_last;

  assign active  = live_q[1];
  assign rq_full = (rq_cnt_q == RCntW'(max_rd_p));
  assign wq_full = (wq_cnt_q == WCntW'(max_wr_p));
  assign rq_act  = active & (rq_cnt_q != '0);
  assign wq_act  = active & (wq_cnt_q != '0);
  assign rq_head = rq_mem_q[rq_rptr_q];
  assign wq_head = wq_mem_q[wq_rptr_q];

  // A full queue blocks its push even if it pops this cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < num_chan_p; i++) begin
      if (chan_pkt_i[i*pkt_width_p + pkt_width_p - 1])
        elig[i] = active & chan_pkt_v_i[i] & ~wq_full;
      else
        elig[i] = active & chan_pkt_v_i[i] & ~rq_full;
    end
  end

  assign any_elig = |elig;

  // A stalled grant stays locked until its handshake so the packet never switches.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    if (lock_v_q && elig[lock_id_q]) begin
      grant = lock_id_q;
    end else if (fixed_prio_p != 0) begin
      for (int i = num_chan_p - 1; i >= 0; i--)
        if (elig[i]) grant = IdW'(i);
    end else begin
      for (int k = num_chan_p - 1; k >= 0; k--) begin
        idx = int'(rr_q) + k;
        if (idx >= num_chan_p) idx = idx - num_chan_p;
        if (elig[IdW'(idx)]) grant = IdW'(idx);
      end
    end
  end

  assign win_pkt     = chan_pkt_i[int'(grant)*pkt_width_p +: pkt_width_p];
  assign dma_pkt_o   = win_pkt;
  assign dma_pkt_v_o = any_elig;
  assign pkt_hs      = any_elig & dma_pkt_ready_and_i;
  assign wq_push     = pkt_hs & win_pkt[pkt_width_p-1];
  assign rq_push     = pkt_hs & ~win_pkt[pkt_width_p-1];

  always_comb begin
    chan_pkt_ready_and_o = '0;
    if (any_elig) chan_pkt_ready_and_o[grant] = dma_pkt_ready_and_i;
  end

  assign dma_data_v_o = wq_act & chan_wdata_v_i[wq_head];
  assign dma_data_o   = chan_wdata_i[int'(wq_head)*data_width_p +: data_width_p];
  assign w_hs         = dma_data_v_o & dma_data_ready_and_i;
  assign w_last       = w_hs & (wcnt_q == BeatW'(block_beats_p - 1));

  always_comb begin
    chan_wdata_ready_and_o = '0;
    if (wq_act) chan_wdata_ready_and_o[wq_head] = dma_data_ready_and_i;
  end

  assign chan_rdata_o         = {num_chan_p{dma_data_i}};
  assign dma_data_ready_and_o = rq_act & chan_rdata_ready_and_i[rq_head];
  assign r_hs                 = rq_act & dma_data_v_i & chan_rdata_ready_and_i[rq_head];
  assign r_last               = r_hs & (rcnt_q == BeatW'(block_beats_p - 1));

  always_comb begin
    chan_rdata_v_o = '0;
    if (rq_act) chan_rdata_v_o[rq_head] = dma_data_v_i;
  end

  always_comb begin
    rr_d = rr_q;
    if (pkt_hs) rr_d = (int'(grant) == num_chan_p - 1) ? '0 : grant + IdW'(1);
    lock_v_d  = any_elig & ~dma_pkt_ready_and_i;
    lock_id_d = grant;

    wcnt_d = wcnt_q;
    if (w_last)    wcnt_d = '0;
    else if (w_hs) wcnt_d = wcnt_q + BeatW'(1);
    rcnt_d = rcnt_q;
    if (r_last)    rcnt_d = '0;
    else if (r_hs) rcnt_d = rcnt_q + BeatW'(1);

    rq_wptr_d = rq_wptr_q;
    if (rq_push) rq_wptr_d = (rq_wptr_q == RPtrW'(max_rd_p - 1)) ? '0 : rq_wptr_q + RPtrW'(1);
    rq_rptr_d = rq_rptr_q;
    if (r_last)  rq_rptr_d = (rq_rptr_q == RPtrW'(max_rd_p - 1)) ? '0 : rq_rptr_q + RPtrW'(1);
    rq_cnt_d  = rq_cnt_q + RCntW'(rq_push) - RCntW'(r_last);

    wq_wptr_d = wq_wptr_q;
    if (wq_push) wq_wptr_d = (wq_wptr_q == WPtrW'(max_wr_p - 1)) ? '0 : wq_wptr_q + WPtrW'(1);
    wq_rptr_d = wq_rptr_q;
    if (w_last)  wq_rptr_d = (wq_rptr_q == WPtrW'(max_wr_p - 1)) ? '0 : wq_rptr_q + WPtrW'(1);
    wq_cnt_d  = wq_cnt_q + WCntW'(wq_push) - WCntW'(w_last);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_q    <= '0;
      rr_q      <= '0;
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      rq_rptr_q <= '0;
      rq_wptr_q <= '0;
      rq_cnt_q  <= '0;
      wq_rptr_q <= '0;
      wq_wptr_q <= '0;
      wq_cnt_q  <= '0;
      for (int i = 0; i < max_rd_p; i++) rq_mem_q[i] <= '0;
      for (int i = 0; i < max_wr_p; i++) wq_mem_q[i] <= '0;
    end else begin
      live_q    <= {live_q[0], 1'b1};
      rr_q      <= rr_d;
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      rq_rptr_q <= rq_rptr_d;
      rq_wptr_q <= rq_wptr_d;
      rq_cnt_q  <= rq_cnt_d;
      wq_rptr_q <= wq_rptr_d;
      wq_wptr_q <= wq_wptr_d;
      wq_cnt_q  <= wq_cnt_d;
      if (rq_push) rq_mem_q[rq_wptr_q] <= grant;
      if (wq_push) wq_mem_q[wq_wptr_q] <= grant;
    end
  end

  // Read-return beats with no outstanding read are a protocol error upstream.
  unexpected_rdata_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(dma_data_v_i && (rq_cnt_q == '0)));

endmodule

// File: tb/tb_bp_me_dma_channel_arbiter.sv
// Randomized bench for bp_me_dma_channel_arbiter: a round-robin instance with full
// data traffic and a fixed-priority instance with packet traffic only, both checked against queue models.
module tb_bp_me_dma_channel_arbiter;
  localparam int N = 3, PW = 33, DW = 64, BEATS = 8, MAXRD = 4, MAXWR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*PW-1:0] chan_pkt;
  logic [N-1:0]    chan_pkt_v, chan_pkt_rdy;
  logic [N*DW-1:0] chan_wdata, chan_rdata;
  logic [N-1:0]    chan_wdata_v, chan_wdata_rdy, chan_rdata_v, chan_rdata_rdy;
  logic [PW-1:0]   dma_pkt;
  logic            dma_pkt_v, dma_pkt_rdy;
  logic [DW-1:0]   dma_wdata, dma_rdata;
  logic            dma_wdata_v, dma_wdata_rdy, dma_rdata_v, dma_rdata_rdy;

  logic [N*PW-1:0] fpkt;
  logic [N-1:0]    fpkt_v, fpkt_rdy, f_wdata_rdy, f_rdata_v;
  logic [PW-1:0]   fdma_pkt;
  logic            fdma_pkt_v, fdma_pkt_rdy, f_dma_data_v, f_dma_rdata_rdy;
  logic [DW-1:0]   f_dma_data;
  logic [N*DW-1:0] f_rdata;

  bp_me_dma_channel_arbiter #(.num_chan_p(N), .pkt_width_p(PW), .data_width_p(DW),
    .block_beats_p(BEATS), .max_rd_p(MAXRD), .max_wr_p(MAXWR), .fixed_prio_p(0)) u_rr (
    .clk_i(clk), .reset_n_i(rst_n),
    .chan_pkt_i(chan_pkt), .chan_pkt_v_i(chan_pkt_v), .chan_pkt_ready_and_o(chan_pkt_rdy),
    .chan_wdata_i(chan_wdata), .chan_wdata_v_i(chan_wdata_v), .chan_wdata_ready_and_o(chan_wdata_rdy),
    .chan_rdata_o(chan_rdata), .chan_rdata_v_o(chan_rdata_v), .chan_rdata_ready_and_i(chan_rdata_rdy),
    .dma_pkt_o(dma_pkt), .dma_pkt_v_o(dma_pkt_v), .dma_pkt_ready_and_i(dma_pkt_rdy),
    .dma_data_o(dma_wdata), .dma_data_v_o(dma_wdata_v), .dma_data_ready_and_i(dma_wdata_rdy),
    .dma_data_i(dma_rdata), .dma_data_v_i(dma_rdata_v), .dma_data_ready_and_o(dma_rdata_rdy));

  bp_me_dma_channel_arbiter #(.num_chan_p(N), .pkt_width_p(PW), .data_width_p(DW),
    .block_beats_p(BEATS), .max_rd_p(MAXRD), .max_wr_p(MAXWR), .fixed_prio_p(1)) u_fix (
    .clk_i(clk), .reset_n_i(rst_n),
    .chan_pkt_i(fpkt), .chan_pkt_v_i(fpkt_v), .chan_pkt_ready_and_o(fpkt_rdy),
    .chan_wdata_i('0), .chan_wdata_v_i('0), .chan_wdata_ready_and_o(f_wdata_rdy),
    .chan_rdata_o(f_rdata), .chan_rdata_v_o(f_rdata_v), .chan_rdata_ready_and_i('0),
    .dma_pkt_o(fdma_pkt), .dma_pkt_v_o(fdma_pkt_v), .dma_pkt_ready_and_i(fdma_pkt_rdy),
    .dma_data_o(f_dma_data), .dma_data_v_o(f_dma_data_v), .dma_data_ready_and_i(1'b0),
    .dma_data_i('0), .dma_data_v_i(1'b0), .dma_data_ready_and_o(f_dma_rdata_rdy));

  int nCompared = 0, nMismatched = 0;
  int rdq[$], wrq[$];
  int rbeat, wbeat, rr, held, liveCnt, frd, fwr, fheld;
  logic [N-1:0] acc, facc;

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] el, input int hold, input int start, input bit fixedP);
    if (hold >= 0 && el[hold]) return hold;
    for (int k = 0; k < N; k++) begin
      int c;
      c = fixedP ? k : (start + k) % N;
      if (el[c]) return c;
    end
    return -1;
  endfunction

  // Requesters hold a packet until it is accepted; data-side signals are free-running.
  task automatic applyStimulus(input int pktPct, input int rdyPct, input int dataPct);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) chan_pkt_v[i] = 1'b0;
      if (!chan_pkt_v[i] && $urandom_range(99) < pktPct) begin
        chan_pkt_v[i] = 1'b1;
        chan_pkt[i*PW +: PW] = {1'($urandom_range(1)), $urandom};
      end
      if (facc[i]) fpkt_v[i] = 1'b0;
      if (!fpkt_v[i] && $urandom_range(99) < pktPct / 2) begin
        fpkt_v[i] = 1'b1;
        fpkt[i*PW +: PW] = {1'($urandom_range(1)), $urandom};
      end
      chan_wdata_v[i] = ($urandom_range(99) < dataPct);
      chan_wdata[i*DW +: DW] = {$urandom, $urandom};
      chan_rdata_rdy[i] = ($urandom_range(99) < dataPct);
    end
    dma_pkt_rdy   = ($urandom_range(99) < rdyPct);
    fdma_pkt_rdy  = ($urandom_range(99) < rdyPct);
    dma_wdata_rdy = ($urandom_range(99) < dataPct);
    dma_rdata_v   = (rdq.size() > 0) && ($urandom_range(99) < dataPct);
    dma_rdata     = {$urandom, $urandom};
  endtask

  task automatic checkCycle();
    logic [N-1:0] el, fel, expRdy, expWRdy, expRV;
    int w, fw, h;
    bit live, pHs, wHs, rHs, expWV, expRRdy;
    #1;
    live = (liveCnt >= 2);
    for (int i = 0; i < N; i++) begin
      el[i]  = live && chan_pkt_v[i] && (chan_pkt[i*PW+PW-1] ? wrq.size() < MAXWR : rdq.size() < MAXRD);
      fel[i] = live && fpkt_v[i] && (fpkt[i*PW+PW-1] ? fwr < MAXWR : frd < MAXRD);
    end
    w  = pickWinner(el, held, rr, 1'b0);
    fw = pickWinner(fel, fheld, 0, 1'b1);

    checkOutput("pkt_v", dma_pkt_v, w >= 0);
    if (w >= 0) checkOutput("pkt_data", dma_pkt, chan_pkt[w*PW +: PW]);
    pHs = (w >= 0) && dma_pkt_rdy;
    expRdy = pHs ? (N'(1) << w) : '0;
    checkOutput("pkt_ready", chan_pkt_rdy, expRdy);

    expWV = 0; expWRdy = '0; wHs = 0;
    if (live && wrq.size() > 0) begin
      h = wrq[0];
      expWV = chan_wdata_v[h];
      expWRdy = dma_wdata_rdy ? (N'(1) << h) : '0;
      if (expWV) checkOutput("wdata", dma_wdata, chan_wdata[h*DW +: DW]);
      wHs = expWV && dma_wdata_rdy;
    end
    checkOutput("wdata_v", dma_wdata_v, expWV);
    checkOutput("wdata_ready", chan_wdata_rdy, expWRdy);

    expRV = '0; expRRdy = 0; rHs = 0;
    if (live && rdq.size() > 0) begin
      h = rdq[0];
      expRV = dma_rdata_v ? (N'(1) << h) : '0;
      expRRdy = chan_rdata_rdy[h];
      rHs = dma_rdata_v && chan_rdata_rdy[h];
    end
    checkOutput("rdata_v", chan_rdata_v, expRV);
    checkOutput("rdata_ready", dma_rdata_rdy, expRRdy);
    if (expRV != '0) checkOutput("rdata_bcast", chan_rdata, {N{dma_rdata}});

    checkOutput("fix_pkt_v", fdma_pkt_v, fw >= 0);
    if (fw >= 0) checkOutput("fix_pkt_data", fdma_pkt, fpkt[fw*PW +: PW]);
    checkOutput("fix_pkt_ready", fpkt_rdy, (fw >= 0 && fdma_pkt_rdy) ? (N'(1) << fw) : N'(0));
    checkOutput("fix_data_idle", {f_dma_data_v, f_wdata_rdy, f_rdata_v, f_dma_rdata_rdy, f_rdata, f_dma_data}, '0);

    if (wHs) begin
      wbeat++;
      if (wbeat == BEATS) begin wbeat = 0; void'(wrq.pop_front()); end
    end
    if (rHs) begin
      rbeat++;
      if (rbeat == BEATS) begin rbeat = 0; void'(rdq.pop_front()); end
    end
    acc = expRdy;
    if (pHs) begin
      if (chan_pkt[w*PW+PW-1]) wrq.push_back(w); else rdq.push_back(w);
      rr = (w + 1) % N;
    end
    held = (w >= 0 && !dma_pkt_rdy) ? w : -1;
    facc = '0;
    if (fw >= 0 && fdma_pkt_rdy) begin
      facc = N'(1) << fw;
      if (fpkt[fw*PW+PW-1]) fwr++; else frd++;
    end
    fheld = (fw >= 0 && !fdma_pkt_rdy) ? fw : -1;
    if (liveCnt < 2) liveCnt++;
    @(negedge clk);
  endtask

  // Reset lands at an arbitrary point, usually in the middle of bursts.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {dma_pkt_v, dma_wdata_v, chan_rdata_v, fdma_pkt_v}, '0);
    checkOutput("rst_ready", {chan_pkt_rdy, chan_wdata_rdy, dma_rdata_rdy, fpkt_rdy}, '0);
    rdq.delete(); wrq.delete();
    rbeat = 0; wbeat = 0; rr = 0; held = -1; liveCnt = 0;
    frd = 0; fwr = 0; fheld = -1;
    chan_pkt_v = '0; fpkt_v = '0; chan_wdata_v = '0; dma_rdata_v = 1'b0;
    acc = '0; facc = '0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int len, pktPct, rdyPct, dataPct;
    chan_pkt = '0; chan_pkt_v = '0; chan_wdata = '0; chan_wdata_v = '0; chan_rdata_rdy = '0;
    dma_pkt_rdy = 1'b0; dma_wdata_rdy = 1'b0; dma_rdata = '0; dma_rdata_v = 1'b0;
    fpkt = '0; fpkt_v = '0; fdma_pkt_rdy = 1'b0;
    @(negedge clk);
    doReset(3);
    for (int seg = 0; seg < 16; seg++) begin
      len = $urandom_range(120, 300);
      case (seg % 4)
        0: begin pktPct = 95; rdyPct = 40; dataPct = 50; end
        1: begin pktPct = 90; rdyPct = 100; dataPct = 95; end
        2: begin pktPct = 60; rdyPct = 70; dataPct = 25; end
        default: begin
          pktPct = $urandom_range(10, 90); rdyPct = $urandom_range(10, 90); dataPct = $urandom_range(10, 90);
        end
      endcase
      for (int c = 0; c < len; c++) begin
        applyStimulus(pktPct, rdyPct, dataPct);
        checkCycle();
      end
      doReset($urandom_range(1, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
